// File: rtl/dcache_data_array_pkg.sv
// Shared types and width helpers for the L1 dcache data array.
// Used by dcache_data_array and its per-way dcache_bank.
package dcache_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } dcache_arr_state_e;

    localparam int unsigned DefNumWays   = 4;
    localparam int unsigned DefDepth     = 256;
    localparam int unsigned DefDataWidth = 64;

    // Way select is at least one bit wide even for a single-way array.
    function automatic int unsigned way_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned addr_width(input int unsigned d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    localparam int unsigned DefWayW  = way_width(DefNumWays);
    localparam int unsigned DefAddrW = addr_width(DefDepth);

    typedef struct packed {
        logic                        we;
        logic [DefWayW-1:0]          way;
        logic [DefAddrW-1:0]         addr;
        logic [DefDataWidth/8-1:0]   be;
        logic [DefDataWidth-1:0]     wdata;
    } dcache_arr_req_t;

endpackage

// File: rtl/dcache_data_array_bank.sv
// One way of the dcache data array: byte-enable write, synchronous read.
// The read register holds its value between reads so the array output is
// stable while no response is in progress.
module dcache_bank
    import dcache_pkg::*;
#(
    parameter int unsigned Depth     = 256,
    parameter int unsigned DataWidth = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           we_i,
    input  logic                           re_i,
    input  logic [addr_width(Depth)-1:0]   addr_i,
    input  logic [DataWidth/8-1:0]         be_i,
    input  logic [DataWidth-1:0]           wdata_i,
    output logic [DataWidth-1:0]           rdata_o
);

    logic [DataWidth-1:0] mem_q [Depth];

    // Storage: update only the enabled bytes of the addressed line.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < DataWidth / 8; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Read register: captures the line on a read and holds it otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_o <= '0;
        end else if (re_i) begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/dcache_data_array.sv
// L1 dcache data array: NumWays byte-writable ways, one request per cycle,
// reads return every way of the set. A zeroing sweep runs after reset and
// after every flush before requests are accepted.
// Optional macro DCACHE_DATA_ARRAY_OREG_EN adds an output register stage
// (read latency 2 instead of 1).
module dcache_data_array
    import dcache_pkg::*;
#(
    parameter int unsigned NumWays   = 4,
    parameter int unsigned Depth     = 256,
    parameter int unsigned DataWidth = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic                              req_we_i,
    input  logic [way_width(NumWays)-1:0]     req_way_i,
    input  logic [addr_width(Depth)-1:0]      req_addr_i,
    input  logic [DataWidth/8-1:0]            req_be_i,
    input  logic [DataWidth-1:0]              req_wdata_i,
    output logic                              rsp_valid_o,
    output logic [NumWays*DataWidth-1:0]      rsp_rdata_o,
    output logic                              init_done_o
);

    localparam int unsigned WayW  = way_width(NumWays);
    localparam int unsigned AddrW = addr_width(Depth);
    localparam int unsigned BeW   = DataWidth / 8;
    localparam int unsigned LineW = NumWays * DataWidth;

    typedef struct packed {
        logic                  we;
        logic [WayW-1:0]       way;
        logic [AddrW-1:0]      addr;
        logic [BeW-1:0]        be;
        logic [DataWidth-1:0]  wdata;
    } req_t;

    dcache_arr_state_e    state_q, state_d;
    logic [AddrW-1:0]     cnt_q, cnt_d;
    logic                 accept;
    logic                 sweep;

    req_t                 req_p0;
    logic                 vld_p0;
    logic                 vld_p1;
    logic [LineW-1:0]     rdata_p1;

    logic [AddrW-1:0]     arr_addr;
    logic [BeW-1:0]       arr_be;
    logic [DataWidth-1:0] arr_wdata;
    logic                 arr_re;

    assign init_done_o = (state_q == READY);
    assign req_ready_o = (state_q == READY) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;
    assign sweep       = (state_q == INIT);

    // State and sweep counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep every set once, flush restarts the sweep from set 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT: begin
                if (flush_i) begin
                    cnt_d = '0;
                end else if (cnt_q == AddrW'(Depth - 1)) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AddrW'(1);
                end
            end
            READY: begin
                if (flush_i) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // ---- p0: accepted request captured ----
    // Request valid; dropped on reset so in-flight reads never respond.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
        end
    end

    // Request payload; only meaningful while vld_p0 is set.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            req_p0 <= '{we: req_we_i, way: req_way_i, addr: req_addr_i,
                        be: req_be_i, wdata: req_wdata_i};
        end
    end

    // The sweep owns the array port during INIT; a captured request can
    // never be pending then because flush blocks acceptance.
    assign arr_addr  = sweep ? cnt_q : req_p0.addr;
    assign arr_be    = sweep ? {BeW{1'b1}} : req_p0.be;
    assign arr_wdata = sweep ? '0 : req_p0.wdata;
    assign arr_re    = vld_p0 && !req_p0.we;

    // ---- p1: array read ----
    for (genvar w = 0; w < NumWays; w++) begin : g_way
        logic way_we;
        // Out-of-range way indices match no bank, so the write is dropped.
        assign way_we = sweep || (vld_p0 && req_p0.we && (req_p0.way == WayW'(w)));

        dcache_bank #(
            .Depth     (Depth),
            .DataWidth (DataWidth)
        ) u_bank (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .we_i    (way_we),
            .re_i    (arr_re),
            .addr_i  (arr_addr),
            .be_i    (arr_be),
            .wdata_i (arr_wdata),
            .rdata_o (rdata_p1[w*DataWidth +: DataWidth])
        );
    end

    // Read response valid aligned with the bank read registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= arr_re;
        end
    end

`ifdef DCACHE_DATA_ARRAY_OREG_EN
    // ---- p2: output register ----
    logic             vld_p2;
    logic [LineW-1:0] rdata_p2;

    // Extra output stage; data only advances with a valid response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p2   <= 1'b0;
            rdata_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                rdata_p2 <= rdata_p1;
            end
        end
    end

    assign rsp_valid_o = vld_p2;
    assign rsp_rdata_o = rdata_p2;
`else
    assign rsp_valid_o = vld_p1;
    assign rsp_rdata_o = rdata_p1;
`endif

endmodule

// File: tb/tb_dcache_data_array.sv
// Bench for dcache_data_array: table of requests with expected read data,
// a response scoreboard, and hand sequences for sweep, flush and reset.
module tb_dcache_data_array;

    localparam int LW = 256;
`ifdef DCACHE_DATA_ARRAY_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk_i       = 1'b0;
    logic          rst_i       = 1'b1;
    logic          flush_i     = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_we_i    = 1'b0;
    logic [1:0]    req_way_i   = '0;
    logic [7:0]    req_addr_i  = '0;
    logic [7:0]    req_be_i    = '0;
    logic [63:0]   req_wdata_i = '0;
    logic          req_ready_o;
    logic          rsp_valid_o;
    logic [LW-1:0] rsp_rdata_o;
    logic          init_done_o;

    dcache_data_array dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_way_i   (req_way_i),
        .req_addr_i  (req_addr_i),
        .req_be_i    (req_be_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .init_done_o (init_done_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [LW-1:0] d;
        int            acc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          we;
        int            way;
        int            addr;
        logic [7:0]    be;
        logic [63:0]   wd;
        logic [LW-1:0] exp;
    } vec_t;
    vec_t vt[13];

    logic [LW-1:0] last_rd = '0;

    localparam logic [63:0] AA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] FIVES = 64'h5555_5555_5555_5555;

    function automatic logic [LW-1:0] line4(input logic [63:0] w0, w1, w2, w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Drive one request (caller sits just after a rising edge); leaves it held.
    task automatic issue(input logic we, input int way, input int addr, input logic [7:0] be,
                         input logic [63:0] wd, input logic [LW-1:0] exp, input string nm);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_way_i   = 2'(way);
        req_addr_i  = 8'(addr);
        req_be_i    = be;
        req_wdata_i = wd;
        @(negedge clk_i);
        check_int({"ready_", nm}, longint'(req_ready_o), 1);
        if (!we) sb.push_back('{exp, cyc + 1});
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
    endtask

    task automatic drain();
        idle();
        repeat (4) @(posedge clk_i);
        #1;
    endtask

    // Count cycles with req_ready_o low, starting just after an edge.
    task automatic wait_ready(input string nm, input int expcnt);
        int n;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 2000) begin
            n++;
            @(negedge clk_i);
        end
        check_int(nm, n, expcnt);
        @(posedge clk_i);
        #1;
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // Response monitor and scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk_i);
        if (rst_i) begin
            sb.delete();
            last_rd = '0;
        end else if (rsp_valid_o) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got valid=1 want no response");
            end else begin
                e = sb.pop_front();
                check("rsp_data", rsp_rdata_o, e.d);
                check_int("rsp_latency", cyc - e.acc, LAT);
            end
            last_rd = rsp_rdata_o;
        end else begin
            check("rdata_hold", rsp_rdata_o, last_rd);
        end
    end

    initial begin
        vt[0]  = '{1'b0, 0, 8'h5A, 8'h00, 64'h0, line4(0, 0, 0, 0)};
        vt[1]  = '{1'b1, 2, 8'h10, 8'h0F, 64'h1122334455667788, '0};
        vt[2]  = '{1'b0, 0, 8'h10, 8'h00, 64'h0, line4(0, 0, 64'h0000000055667788, 0)};
        vt[3]  = '{1'b1, 0, 8'h10, 8'h80, 64'hFFFF_FFFF_FFFF_FFFF, '0};
        vt[4]  = '{1'b0, 0, 8'h10, 8'h00, 64'h0,
                   line4(64'hFF00000000000000, 0, 64'h0000000055667788, 0)};
        vt[5]  = '{1'b1, 1, 8'h10, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF, '0};
        vt[6]  = '{1'b0, 0, 8'h10, 8'h00, 64'h0,
                   line4(64'hFF00000000000000, 0, 64'h0000000055667788, 0)};
        vt[7]  = '{1'b1, 3, 8'h03, 8'hFF, AA, '0};
        vt[8]  = '{1'b0, 0, 8'h03, 8'h00, 64'h0, line4(0, 0, 0, AA)};
        vt[9]  = '{1'b0, 0, 8'h04, 8'h00, 64'h0, line4(0, 0, 0, 0)};
        vt[10] = '{1'b0, 0, 8'h03, 8'h00, 64'h0, line4(0, 0, 0, AA)};
        vt[11] = '{1'b1, 2, 8'h10, 8'hF0, 64'h1122334455667788, '0};
        vt[12] = '{1'b0, 0, 8'h10, 8'h00, 64'h0,
                   line4(64'hFF00000000000000, 0, 64'h1122334455667788, 0)};

        // Reset values and initial sweep with a read held pending.
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_int("rst_ready", req_ready_o, 0);
        check_int("rst_valid", rsp_valid_o, 0);
        check("rst_rdata", rsp_rdata_o, '0);
        check_int("rst_init_done", init_done_o, 0);
        @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 8'h5A;
        wait_ready("sweep_cycles", 256);
        sb.push_back('{line4(0, 0, 0, 0), cyc});
        idle();
        check_int("init_done_up", init_done_o, 1);
        drain();

        // Table vectors, back to back.
        for (int i = 0; i < 13; i++) begin
            issue(vt[i].we, vt[i].way, vt[i].addr, vt[i].be, vt[i].wd, vt[i].exp,
                  $sformatf("vec%0d", i));
        end
        drain();

        // Flush colliding with a write to set 7.
        issue(1'b1, 1, 7, 8'hFF, 64'h0123456789ABCDEF, '0, "w7");
        issue(1'b0, 0, 7, 8'h00, 64'h0, line4(0, 64'h0123456789ABCDEF, 0, 0), "r7");
        drain();
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_way_i   = 2'd1;
        req_addr_i  = 8'h07;
        req_be_i    = 8'hFF;
        req_wdata_i = 64'hCAFE_CAFE_CAFE_CAFE;
        @(negedge clk_i);
        check_int("flush_ready", req_ready_o, 0);
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        idle();
        check_int("flush_init_done", init_done_o, 0);
        wait_ready("reflush_cycles", 256);
        issue(1'b0, 0, 7, 8'h00, 64'h0, line4(0, 0, 0, 0), "r7_after");
        issue(1'b0, 0, 8'h10, 8'h00, 64'h0, line4(0, 0, 0, 0), "r10_after");
        drain();

        // Flush with a read in flight.
        issue(1'b1, 0, 1, 8'hFF, FIVES, '0, "w1");
        issue(1'b0, 0, 1, 8'h00, 64'h0, line4(FIVES, 0, 0, 0), "r1");
        idle();
        flush_i = 1'b1;
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
        check_int("inflight_init_done", init_done_o, 0);
        wait_ready("inflight_sweep", 256);

        // Reset just after a read is accepted.
        issue(1'b0, 0, 3, 8'h00, 64'h0, line4(0, 0, 0, 0), "r_rst");
        idle();
        rst_i = 1'b1;
        #1;
        check_int("midrst_ready", req_ready_o, 0);
        check_int("midrst_valid", rsp_valid_o, 0);
        check("midrst_rdata", rsp_rdata_o, '0);
        check_int("midrst_init_done", init_done_o, 0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        wait_ready("midrst_sweep", 256);
        issue(1'b0, 0, 1, 8'h00, 64'h0, line4(0, 0, 0, 0), "r1_after_rst");
        drain();

        check_int("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_data_array.md
# dcache_data_array

Multi-way, byte-writable data array for the L1 data cache: stores `NumWays` ways of `Depth` lines each, `DataWidth` bits per line. Each cycle it accepts one read or write request over a valid/ready handshake. A read returns every way of the indexed set, and the cache controller selects the hit way downstream. After reset or flush, an internal sweep zeroes the whole array before any request is accepted. The block sits between the dcache controller and the tag/hit logic.

## Interface
- `NumWays`, default 4: number of ways; must be ≥1.
- `Depth`, default 256: sets per way; must be a power of two, ≥2.
- `DataWidth`, default 64: bits per line; must be a multiple of 8.
- `clk_i`, input, 1: the only clock; all state updates on its rising edge.
- `rst_i`, input, 1: asynchronous, active-high reset.
- `flush_i`, input, 1: single-cycle pulse that restarts the zeroing sweep.
- `req_valid_i`, input, 1: request present.
- `req_ready_o`, output, 1: request can be accepted this cycle.
- `req_we_i`, input, 1: 1 = write, 0 = read.
- `req_way_i`, input, `$clog2(NumWays)` (minimum 1): way to write; ignored on reads.
- `req_addr_i`, input, `$clog2(Depth)`: set index.
- `req_be_i`, input, `DataWidth/8`: byte enables for writes; ignored on reads.
- `req_wdata_i`, input, `DataWidth`: write data.
- `rsp_valid_o`, output, 1: read data is valid this cycle.
- `rsp_rdata_o`, output, `NumWays×DataWidth`: all ways of the read set; way *w* occupies bits [w·DataWidth +: DataWidth].
- `init_done_o`, output, 1: high once the sweep has completed.

## Operation
- States: `INIT` and `READY`. Reset enters `INIT` with the sweep counter at 0.
- In `INIT`:
  - Each cycle, write all-zero to set `counter` in every way, then increment the counter.
  - When `counter == Depth-1` has been written, move to `READY`.
  - The sweep takes exactly `Depth` cycles.
- `req_ready_o = (state == READY) && !flush_i`. It is combinational and does not depend on `req_valid_i`.
- A request is accepted when `req_valid_i && req_ready_o` at a rising edge.
- Write acceptance:
  - Only way `req_way_i` at set `req_addr_i` changes.
  - Byte *b* is updated only where `req_be_i[b]` is 1; all other bytes and ways hold.
  - A write produces no response.
  - Writing with `req_be_i == 0` is legal and changes nothing.
- Read acceptance: produces exactly one `rsp_valid_o` pulse carrying the stored contents of all ways.
- Back-to-back reads: one per cycle, responses in order. There is no response backpressure; the consumer must take each response in its valid cycle.
- Read after write: a read accepted the cycle after a write to the same set returns the new data.
- `flush_i` in `READY`:
  - Next state is `INIT`, counter cleared, `init_done_o` falls.
  - If `flush_i` and `req_valid_i` coincide, the request is not accepted.
  - Reads already in flight still complete, with their pre-flush data.
- `flush_i` during `INIT` restarts the sweep at 0.
- `rsp_rdata_o` holds its last value while `rsp_valid_o` is 0.
- Out-of-range `req_way_i` (when `NumWays` is not a power of two): the write is dropped.

## Timing
- Reset values: `req_ready_o` = 0, `rsp_valid_o` = 0, `rsp_rdata_o` = 0, `init_done_o` = 0, state `INIT`, counter 0.
- `rst_i` asserted mid-operation:
  - Immediately forces the reset values.
  - Discards in-flight responses.
  - Restarts the sweep once `rst_i` is released.
- `init_done_o` rises on the first cycle of `READY`, which is `Depth` cycles after reset release.
- Read latency, base build: a read accepted at edge N gives `rsp_valid_o` = 1 in the cycle after edge N+1 (1-cycle latency).
- Read latency with the output register compiled in: 2 cycles (edge N+2).
- Write latency: the write is visible to a read accepted at edge N+1.

## Configuration
- Macro `DCACHE_DATA_ARRAY_OREG_EN`.
- Defined: adds an output register stage after the array read.
  - Read latency is 2.
  - `rsp_valid_o` and `rsp_rdata_o` are both registered an extra cycle.
  - Throughput is still 1 read per cycle.
- Undefined: read latency is 1, with no extra stage.

## Structure
- Package `dcache_pkg` holds:
  - enum `dcache_arr_state_e` (`INIT`, `READY`);
  - typedef `dcache_arr_req_t` (`we`, `way`, `addr`, `be`, `wdata`);
  - localparam helpers for address and way widths.
- Sub-module `dcache_bank`: one way with a byte-enable write and a synchronous read. It is instantiated `NumWays` times. The top level owns the FSM, sweep counter, handshake and optional output stage.

## Test plan
1. **Reset and sweep.** Release `rst_i` with `Depth` = 256 and hold `req_valid_i`.
   - `req_ready_o` = 0 for exactly 256 cycles.
   - `init_done_o` rises in cycle 256.
   - A read of set 0x5A then returns 0 in all ways.
2. **Byte-enable write.** Write way 2, set 0x10, data 0x1122334455667788, `req_be_i` = 0x0F, then read set 0x10.
   - Way 2 = 0x0000000055667788.
   - Other ways = 0.
   - Response arrives at latency 1, or 2 with the macro defined.
3. **Back-to-back.** Write set 3 (data 0xAA…), then in consecutive cycles read sets 3, 4, 3.
   - Three consecutive `rsp_valid_o` pulses.
   - First and third carry 0xAA… in the written way.
4. **Flush collision.** Assert `flush_i` and a write to set 7 in the same cycle.
   - `req_ready_o` = 0 that cycle and the write is dropped.
   - `init_done_o` falls.
   - After the 256-cycle re-sweep, set 7 reads 0.
5. **Reset mid-read.** Accept a read, then assert `rst_i` in the following cycle.
   - `rsp_valid_o` never pulses for that read.
   - All outputs are at their reset values while `rst_i` is high.
6. **Flush with read in flight.** Build with the macro defined; accept a read of set 1 holding 0x55…, then assert `flush_i` at N+1.
   - Response at N+2 = 0x55….
   - State goes to `INIT`.
